// File: rtl/fifo_egress_scheduler.sv
// Packet-granular weighted round-robin scheduler draining N_FIFO AXI-stream queues onto one egress port.
// Define SCHED_STRICT_PRIO_EN to give queue 0 absolute priority over the WRR-scheduled queues.
module fifo_egress_scheduler #(
  parameter int N_FIFO          = 3,
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int WEIGHT_WIDTH    = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_FIFO*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N_FIFO*AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [N_FIFO-1:0]                   s_axis_tvalid,
  output logic [N_FIFO-1:0]                   s_axis_tready,
  input  logic [N_FIFO-1:0]                   s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  input  logic [N_FIFO*WEIGHT_WIDTH-1:0]      cfg_weight,
  input  logic [N_FIFO-1:0]                   cfg_enable,
  output logic [N_FIFO-1:0]                   stat_grant,
  output logic                                stat_busy
);

  localparam int IDX_W = (N_FIFO > 1) ? $clog2(N_FIFO) : 1;

  typedef enum logic [1:0] {IDLE, RELOAD, XFER} state_t;

  state_t                  state_q, state_d;
  logic [N_FIFO-1:0]       req;
  logic [WEIGHT_WIDTH-1:0] credit_q [N_FIFO];
  logic [IDX_W-1:0]        rr_ptr_q, gnt_idx_q, win_idx, cand;
  logic [WEIGHT_WIDTH-1:0] cand_credit;
  logic                    win_found, win_prio, gnt_prio_q;
  logic [N_FIFO-1:0]       grant_q;
  logic                    last_hs;

  function automatic logic [WEIGHT_WIDTH-1:0] sat_dec(input logic [WEIGHT_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - WEIGHT_WIDTH'(1);
  endfunction

  always_comb begin
    req = '0;
    for (int i = 0; i < N_FIFO; i++) begin
      req[i] = s_axis_tvalid[i] & cfg_enable[i] & (cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
    end
  end

  // RELOAD arbitrates against the weights being loaded, so a refill costs exactly one cycle.
  always_comb begin
    win_found   = 1'b0;
    win_idx     = '0;
    win_prio    = 1'b0;
    cand        = '0;
    cand_credit = '0;
`ifdef SCHED_STRICT_PRIO_EN
    if (s_axis_tvalid[0] && cfg_enable[0]) begin
      win_found = 1'b1;
      win_prio  = 1'b1;
    end
`endif
    for (int k = 1; k <= N_FIFO; k++) begin
      cand        = IDX_W'((int'(rr_ptr_q) + k) % N_FIFO);
      cand_credit = (state_q == RELOAD) ? cfg_weight[cand*WEIGHT_WIDTH +: WEIGHT_WIDTH]
                                        : credit_q[cand];
      if (!win_found && req[cand] && (cand_credit != '0)) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign last_hs = (state_q == XFER) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win_found)  state_d = XFER;
        else if (|req)  state_d = RELOAD;
      end
      RELOAD:  state_d = win_found ? XFER : IDLE;
      XFER:    if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == XFER) begin
      m_axis_tdata             = s_axis_tdata[gnt_idx_q*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
      m_axis_tkeep             = s_axis_tkeep[gnt_idx_q*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
      m_axis_tvalid            = s_axis_tvalid[gnt_idx_q];
      m_axis_tlast             = s_axis_tlast[gnt_idx_q];
      s_axis_tready[gnt_idx_q] = m_axis_tready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDX_W'(N_FIFO - 1);
      gnt_idx_q  <= '0;
      grant_q    <= '0;
      gnt_prio_q <= 1'b0;
      for (int i = 0; i < N_FIFO; i++) credit_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RELOAD) begin
        for (int i = 0; i < N_FIFO; i++) credit_q[i] <= cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
      if ((state_q != XFER) && win_found) begin
        gnt_idx_q  <= win_idx;
        grant_q    <= N_FIFO'(1) << win_idx;
        gnt_prio_q <= win_prio;
        if (!win_prio) rr_ptr_q <= win_idx;
      end
      // A priority grant of queue 0 rides outside the WRR credit accounting.
      if (last_hs) begin
        grant_q <= '0;
        if (!gnt_prio_q) credit_q[gnt_idx_q] <= sat_dec(credit_q[gnt_idx_q]);
      end
    end
  end

  assign stat_grant = grant_q;
  assign stat_busy  = (state_q == XFER);

endmodule

// File: tb/tb_fifo_egress_scheduler.sv
// Directed bench for fifo_egress_scheduler: queue sources replay stored frames, egress beats are logged and compared.
`timescale 1ns/1ps
module tb_fifo_egress_scheduler;
  localparam int N = 3, DW = 64, KW = 8, WW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tvalid, s_tready, s_tlast;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid, m_tready, m_tlast;
  logic [N*WW-1:0] cfg_weight;
  logic [N-1:0]    cfg_enable, stat_grant;
  logic            stat_busy;

  fifo_egress_scheduler #(.N_FIFO(N), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .WEIGHT_WIDTH(WW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .cfg_weight(cfg_weight), .cfg_enable(cfg_enable),
    .stat_grant(stat_grant), .stat_busy(stat_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t       mem [N][64];
  int          rd [N];
  int          wr [N];
  logic [N-1:0] gap;
  beat_t       log_b [128];
  int          log_q [128];
  int          log_c [128];
  int          nlog;
  int          cyc;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gidx(input logic [N-1:0] g);
    case (g)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic push_frame(input int q, input int frm, input int nb);
    for (int k = 0; k < nb; k++) begin
      mem[q][wr[q]] = '{data: {8'(q), 8'(frm), 8'(k), 40'h5AC3960FE1},
                        keep: (k == nb - 1) ? 8'h0F : (8'hFF ^ 8'(k)),
                        last: (k == nb - 1)};
      wr[q]++;
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b = (rd[i] < wr[i]) ? mem[i][rd[i]] : '0;
      s_tvalid[i]          = (rd[i] < wr[i]) && !gap[i];
      s_tdata[i*DW +: DW]  = b.data;
      s_tkeep[i*KW +: KW]  = b.keep;
      s_tlast[i]           = b.last;
    end
  endtask

  task automatic tick();
    logic [N-1:0] fire;
    fire = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      log_b[nlog] = '{data: m_tdata, keep: m_tkeep, last: m_tlast};
      log_q[nlog] = gidx(stat_grant);
      log_c[nlog] = cyc;
      nlog++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (fire[i]) rd[i]++;
    drive();
    #1;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    gap  = '0;
    nlog = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_sources();
    m_tready = 1'b1;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int exp_ord [12];
    int fc [N];
    int base0;
    int gap_done;
    beat_t e;

    // Reset state with a queue presenting data
    rst_n      = 1'b0;
    cfg_weight = {8'd1, 8'd1, 8'd1};
    cfg_enable = 3'b111;
    m_tready   = 1'b1;
    clear_sources();
    push_frame(0, 0, 2);
    drive();
    #3;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", m_tkeep, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_stat_grant", stat_grant, 0);
    chk("rst_stat_busy", stat_busy, 0);

    // Queue 1 four-beat frame after reset: RELOAD then beats at cycles 2..5
    cfg_weight = {8'd1, 8'd1, 8'd1};
    do_reset();
    push_frame(1, 0, 4);
    drive();
    #1;
    chk("t1_c0_vld", m_tvalid, 0);
    tick();
    chk("t1_c1_vld", m_tvalid, 0);
    chk("t1_c1_busy", stat_busy, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      e = mem[1][k];
      chk("t1_vld", m_tvalid, 1);
      chk("t1_data", m_tdata, e.data);
      chk("t1_keep", m_tkeep, e.keep);
      chk("t1_last", m_tlast, e.last);
      chk("t1_grant", stat_grant, 3'b010);
      chk("t1_sready", s_tready, 3'b010);
      tick();
    end
    chk("t1_end_busy", stat_busy, 0);
    chk("t1_end_grant", stat_grant, 0);

    // WRR weights q0=3 q1=1 q2=2, all backlogged with single-beat frames
    cfg_weight = {8'd2, 8'd1, 8'd3};
    do_reset();
    for (int f = 0; f < 6; f++) push_frame(0, f, 1);
    for (int f = 0; f < 2; f++) push_frame(1, f, 1);
    for (int f = 0; f < 4; f++) push_frame(2, f, 1);
    drive();
    #1;
    for (int t = 0; t < 80 && nlog < 12; t++) tick();
    chk("t2_frames", nlog, 12);
    exp_ord = '{0, 1, 2, 0, 2, 0, 1, 2, 0, 2, 0, 0};
    for (int i = 0; i < N; i++) fc[i] = 0;
    for (int i = 0; i < 12; i++) begin
      chk("t2_order", log_q[i], exp_ord[i]);
      e = mem[exp_ord[i]][fc[exp_ord[i]]];
      fc[exp_ord[i]]++;
      chk("t2_data", log_b[i].data, e.data);
    end
    chk("t2_first_cyc", log_c[0], 2);
    chk("t2_gap_same_round", log_c[1] - log_c[0], 2);
    chk("t2_gap_reload", log_c[6] - log_c[5], 3);

    // Queue 2 frame under sink back-pressure and a source bubble; queue 0 waits
    nlog     = 0;
    base0    = wr[0];
    gap_done = 0;
    push_frame(2, 7, 5);
    push_frame(0, 9, 2);
    drive();
    #1;
    for (int t = 0; t < 40 && rd[2] < 5; t++) begin
      m_tready = ~m_tready;
      if (rd[2] == 2 && gap_done == 0 && stat_busy) begin
        gap[2]   = 1'b1;
        gap_done = 1;
      end else begin
        gap[2] = 1'b0;
      end
      drive();
      #1;
      chk("t3_other_tready", s_tready[1:0], 2'b00);
      if (gap[2]) chk("t3_bubble_vld", m_tvalid, 0);
      tick();
    end
    chk("t3_q2_done", rd[2], 5);
    m_tready = 1'b1;
    drive();
    #1;
    for (int t = 0; t < 20 && nlog < 7; t++) tick();
    chk("t3_beats", nlog, 7);
    for (int k = 0; k < 5; k++) begin
      e = mem[2][4 + k];
      chk("t3_src", log_q[k], 2);
      chk("t3_beat", log_b[k], e);
    end
    for (int k = 0; k < 2; k++) begin
      e = mem[0][base0 + k];
      chk("t3_q0_src", log_q[5 + k], 0);
      chk("t3_q0_beat", log_b[5 + k], e);
    end

    // cfg_enable[0] dropped mid-frame: frame completes, later queue 0 frames held
    cfg_weight = {8'd1, 8'd1, 8'd1};
    cfg_enable = 3'b111;
    do_reset();
    push_frame(0, 0, 3);
    push_frame(0, 1, 1);
    push_frame(1, 0, 1);
    push_frame(2, 0, 1);
    drive();
    #1;
    tick();
    tick();
    tick();
    cfg_enable = 3'b110;
    #1;
    chk("t4_hold_vld", m_tvalid, 1);
    chk("t4_hold_grant", stat_grant, 3'b001);
    for (int t = 0; t < 30 && nlog < 5; t++) tick();
    for (int t = 0; t < 5; t++) tick();
    chk("t4_beats", nlog, 5);
    chk("t4_src0", log_q[0], 0);
    chk("t4_src2", log_q[2], 0);
    chk("t4_last", log_b[2].last, 1);
    chk("t4_src3", log_q[3], 1);
    chk("t4_src4", log_q[4], 2);
    chk("t4_q0_held", rd[0], 3);
    chk("t4_idle_busy", stat_busy, 0);
    chk("t4_idle_tready", s_tready, 0);
    cfg_enable = 3'b111;

    // Reset pulsed while beat 2 of a five-beat frame is on the bus
    do_reset();
    push_frame(1, 0, 5);
    drive();
    #1;
    tick();
    tick();
    tick();
    tick();
    chk("t5_pre_vld", m_tvalid, 1);
    chk("t5_pre_data", m_tdata, mem[1][2].data);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", m_tvalid, 0);
    chk("t5_rst_tready", s_tready, 0);
    chk("t5_rst_busy", stat_busy, 0);
    chk("t5_rst_grant", stat_grant, 0);
    chk("t5_rst_data", m_tdata, 0);
    tick();
    rst_n = 1'b1;
    cyc   = 0;
    #1;
    chk("t5_beats_before", nlog, 2);
    chk("t5_src_pos", rd[1], 2);
    chk("t5_c0_vld", m_tvalid, 0);
    tick();
    chk("t5_c1_vld", m_tvalid, 0);
    tick();
    chk("t5_c2_vld", m_tvalid, 1);
    chk("t5_c2_data", m_tdata, mem[1][2].data);

    // Queue 0 with zero weight against queue 1
    cfg_weight = {8'd1, 8'd1, 8'd0};
    do_reset();
    push_frame(0, 0, 1);
    push_frame(0, 1, 1);
    push_frame(1, 0, 1);
    push_frame(1, 1, 1);
    drive();
    #1;
    for (int t = 0; t < 30; t++) tick();
`ifdef SCHED_STRICT_PRIO_EN
    chk("t6_beats", nlog, 4);
    chk("t6_src0", log_q[0], 0);
    chk("t6_src1", log_q[1], 0);
    chk("t6_src2", log_q[2], 1);
    chk("t6_src3", log_q[3], 1);
    chk("t6_first_cyc", log_c[0], 1);
`else
    chk("t6_beats", nlog, 2);
    chk("t6_src0", log_q[0], 1);
    chk("t6_src1", log_q[1], 1);
    chk("t6_q0_unserved", rd[0], 0);
    chk("t6_first_cyc", log_c[0], 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
